alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width in bits.
REQ-002 SHALL have port clk  input  1  single rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  operation request present.
REQ-005 SHALL have port in_ready  output  1  unit accepts request this cycle.
REQ-006 SHALL have port alu_ctrl  input  3  ALUControl code from the ALU decoder.
REQ-007 SHALL have ports src_a, src_b  input  XLEN  operands.
REQ-008 SHALL have port out_valid  output  1  result register holds a valid result.
REQ-009 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-010 SHALL have port result  output  XLEN  registered result.
REQ-011 SHALL have port zero  output  1  registered (result == 0).
REQ-012 SHALL have port illegal  output  1  registered flag: alu_ctrl was unsupported.

Function
REQ-013 SHALL accept a request on a rising edge where in_valid && in_ready.
REQ-014 SHALL decode alu_ctrl: 000 add, 001 sub (a-b), 010 and, 011 or, 101 slt (signed, result 1/0 zero-extended), 100 sll (only when ALU_SHIFT_EN).
REQ-015 SHALL wrap add/sub modulo 2^XLEN; no carry/overflow output.
REQ-016 SHALL, for single-cycle ops, load result/zero/illegal and set out_valid on the accept edge (latency 1).
REQ-017 SHALL hold result, zero, illegal, out_valid stable while out_valid && !out_ready.
REQ-018 SHALL drive in_ready = (state==IDLE) && (!out_valid || out_ready); back-to-back accepts at 1 per cycle when out_ready=1.
REQ-019 SHALL clear out_valid on the edge where out_valid && out_ready and no new result is loaded.
REQ-020 SHALL, for unsupported codes (110, 111, and 100 without ALU_SHIFT_EN), return result=0, zero=1, illegal=1, latency 1.
REQ-021 SHALL use FSM states IDLE, SHIFT, DONE; IDLE->SHIFT on sll accept; SHIFT->DONE when remaining count hits 0; DONE->IDLE on the edge that loads the result register, which occurs when !out_valid || out_ready.
REQ-022 SHALL perform sll one bit per cycle, count = src_b[4:0]; shift-by-0 goes SHIFT->DONE after one cycle; result visible shamt+2 cycles after accept at most.
REQ-023 SHALL deassert in_ready in SHIFT and DONE.

Reset
REQ-024 SHALL on rst_n low asynchronously force state=IDLE, out_valid=0, result=0, zero=0, illegal=0, shift counter=0.
REQ-025 SHALL abort any in-flight shift on reset; no result emitted for it.
REQ-026 SHALL present in_ready=1 in the first cycle after reset release.

Configuration
REQ-027 SHALL use macro ALU_SHIFT_EN: defined -> code 100 executes iterative sll via SHIFT/DONE states; undefined -> code 100 is illegal per REQ-020, the shift counter and SHIFT/DONE logic are absent, and state stays IDLE.

Structure
REQ-028 SHALL place ALUControl code constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL) and the FSM state type in shared package alu_pkg, also used by the ALU decoder.
REQ-029 SHALL instantiate combinational sub-module alu_core (single-cycle ops + illegal detect); FSM, shifter and registers live in alu_exec_unit.

Verification
REQ-030 SHALL test add 0xFFFFFFFF+1, out_ready=1 -> next cycle out_valid=1, result=0, zero=1, illegal=0.
REQ-031 SHALL test slt a=0xFFFFFFFE(-2), b=1 -> result=1; sub 5-7 -> 0xFFFFFFFE, zero=0.
REQ-032 SHALL test out_ready=0 for 3 cycles after or 0xF0|0x0F -> result 0xFF held, in_ready=0, then single accept when out_ready=1.
REQ-033 SHALL test sll a=1, b=4 (ALU_SHIFT_EN) -> in_ready=0 during shift, result=0x10 within 6 cycles; without macro -> illegal=1, result=0 next cycle.
REQ-034 SHALL test alu_ctrl=111 -> illegal=1, zero=1, result=0; and assert rst_n mid-sll -> out_valid=0, state IDLE, in_ready=1 after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALUControl encodings and execution-unit FSM state type, used by the
// ALU decoder and the execution unit. Optional iterative shift: ALU_SHIFT_EN.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_t;

  function automatic logic is_shift_op(input logic [2:0] ctrl);
    return (ctrl == ALU_SLL);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU ops plus unsupported-code detection.
// With ALU_SHIFT_EN the sll code is legal here but executed by the parent.
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      alu_ctrl,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  logic slt_s;

  assign slt_s = ($signed(src_a) < $signed(src_b));

  // Operation select; unsupported codes yield zero with the illegal flag
  always_comb begin
    result  = {XLEN{1'b0}};
    illegal = 1'b0;
    case (alu_ctrl)
      ALU_ADD: result = src_a + src_b;
      ALU_SUB: result = src_a - src_b;
      ALU_AND: result = src_a & src_b;
      ALU_OR:  result = src_a | src_b;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, slt_s};
      ALU_SLL: begin
`ifdef ALU_SHIFT_EN
        illegal = 1'b0;
`else
        illegal = 1'b1;
`endif
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: valid/ready request in, registered result out.
// Define ALU_SHIFT_EN to enable the iterative one-bit-per-cycle sll path.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      alu_ctrl,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  logic [XLEN-1:0] core_result_s;
  logic            core_illegal_s;
  logic            accept_s;
  logic            out_free_s;
  logic            shift_start_s;
  logic            shift_load_s;
  logic [XLEN-1:0] shift_result_s;
  alu_state_t      state_s;

  logic            out_valid_r, out_valid_nxt_s;
  logic [XLEN-1:0] result_r, result_nxt_s;
  logic            zero_r, zero_nxt_s;
  logic            illegal_r, illegal_nxt_s;

  alu_core #(.XLEN(XLEN)) u_core (
    .alu_ctrl (alu_ctrl),
    .src_a    (src_a),
    .src_b    (src_b),
    .result   (core_result_s),
    .illegal  (core_illegal_s)
  );

  // Output slot is free when empty or being drained this cycle
  assign out_free_s = !out_valid_r || out_ready;
  assign in_ready   = (state_s == IDLE) && out_free_s;
  assign accept_s   = in_valid && in_ready;

`ifdef ALU_SHIFT_EN
  alu_state_t      state_r, state_nxt_s;
  logic [4:0]      shift_cnt_r, shift_cnt_nxt_s;
  logic [XLEN-1:0] shift_val_r, shift_val_nxt_s;

  assign state_s        = state_r;
  assign shift_start_s  = accept_s && is_shift_op(alu_ctrl);
  assign shift_load_s   = (state_r == DONE) && out_free_s;
  assign shift_result_s = shift_val_r;

  // Shifter FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      shift_cnt_r <= 5'd0;
      shift_val_r <= {XLEN{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      shift_cnt_r <= shift_cnt_nxt_s;
      shift_val_r <= shift_val_nxt_s;
    end
  end

  // Next state: one bit of shift per cycle, DONE waits for the output slot
  always_comb begin
    state_nxt_s     = state_r;
    shift_cnt_nxt_s = shift_cnt_r;
    shift_val_nxt_s = shift_val_r;
    case (state_r)
      IDLE: begin
        if (shift_start_s) begin
          state_nxt_s     = SHIFT;
          shift_cnt_nxt_s = src_b[4:0];
          shift_val_nxt_s = src_a;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (shift_cnt_r == 5'd0) begin
          state_nxt_s = DONE;
        end else begin
          shift_cnt_nxt_s = shift_cnt_r - 5'd1;
          shift_val_nxt_s = {shift_val_r[XLEN-2:0], 1'b0};
        end
      end
      DONE: begin
        if (shift_load_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end
`else
  assign state_s        = IDLE;
  assign shift_start_s  = 1'b0;
  assign shift_load_s   = 1'b0;
  assign shift_result_s = {XLEN{1'b0}};
`endif

  // Result register load: single-cycle op, finished shift, or drain
  always_comb begin
    out_valid_nxt_s = out_valid_r;
    result_nxt_s    = result_r;
    zero_nxt_s      = zero_r;
    illegal_nxt_s   = illegal_r;
    if (accept_s && !shift_start_s) begin
      out_valid_nxt_s = 1'b1;
      result_nxt_s    = core_result_s;
      zero_nxt_s      = (core_result_s == {XLEN{1'b0}});
      illegal_nxt_s   = core_illegal_s;
    end else if (shift_load_s) begin
      out_valid_nxt_s = 1'b1;
      result_nxt_s    = shift_result_s;
      zero_nxt_s      = (shift_result_s == {XLEN{1'b0}});
      illegal_nxt_s   = 1'b0;
    end else if (out_valid_r && out_ready) begin
      out_valid_nxt_s = 1'b0;
    end else begin
      out_valid_nxt_s = out_valid_r;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      result_r    <= {XLEN{1'b0}};
      zero_r      <= 1'b0;
      illegal_r   <= 1'b0;
    end else begin
      out_valid_r <= out_valid_nxt_s;
      result_r    <= result_nxt_s;
      zero_r      <= zero_nxt_s;
      illegal_r   <= illegal_nxt_s;
    end
  end

  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign zero      = zero_r;
  assign illegal   = illegal_r;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: scoreboard of expected results plus
// directed scenario tasks. Covers both ALU_SHIFT_EN builds.
module tb_alu_exec_unit;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] res;
    logic            zero;
    logic            ill;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      alu_ctrl;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  int   checks = 0;
  int   fails  = 0;
  exp_t sb[$];

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [2:0] c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    exp_t e;
    e.ill = 1'b0;
    case (c)
      3'b000: e.res = a + b;
      3'b001: e.res = a - b;
      3'b010: e.res = a & b;
      3'b011: e.res = a | b;
      3'b101: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef ALU_SHIFT_EN
      3'b100: e.res = a << b[4:0];
`endif
      default: begin e.res = 32'd0; e.ill = 1'b1; end
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  // Scoreboard: every output handshake must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got result=%h zero=%b illegal=%b, required no output", result, zero, illegal);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({result, zero, illegal} !== {e.res, e.zero, e.ill}) begin
          fails++;
          $display("FAIL sb_result: got result=%h zero=%b illegal=%b, required result=%h zero=%b illegal=%b",
                   result, zero, illegal, e.res, e.zero, e.ill);
        end
      end
    end
  end

  // Starts and ends at posedge+1; returns the number of stalled cycles
  task automatic send(input logic [2:0] c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, output int waited);
    alu_ctrl = c; src_a = a; src_b = b; in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++; fails++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
    end else begin
      sb.push_back(model(c, a, b));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain;
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_ctrl = 3'b000; src_a = 32'd0; src_b = 32'd0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
    checks++; if (result !== 32'd0) begin fails++; $display("FAIL rst_result: got %h, required 0", result); end
    checks++; if (zero !== 1'b0) begin fails++; $display("FAIL rst_zero: got %b, required 0", zero); end
    checks++; if (illegal !== 1'b0) begin fails++; $display("FAIL rst_illegal: got %b, required 0", illegal); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_add_wrap;
    int w;
    out_ready = 1'b1;
    send(3'b000, 32'hFFFF_FFFF, 32'd1, w);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL add_valid: got %b, required 1", out_valid); end
    checks++; if (result !== 32'd0) begin fails++; $display("FAIL add_result: got %h, required 0", result); end
    checks++; if (zero !== 1'b1) begin fails++; $display("FAIL add_zero: got %b, required 1", zero); end
    checks++; if (illegal !== 1'b0) begin fails++; $display("FAIL add_illegal: got %b, required 0", illegal); end
    @(posedge clk); #1;
  endtask

  task automatic test_slt_sub;
    int w;
    out_ready = 1'b1;
    send(3'b101, 32'hFFFF_FFFE, 32'd1, w);
    @(negedge clk);
    checks++; if (result !== 32'd1) begin fails++; $display("FAIL slt_result: got %h, required 1", result); end
    @(posedge clk); #1;
    send(3'b001, 32'd5, 32'd7, w);
    @(negedge clk);
    checks++; if (result !== 32'hFFFF_FFFE) begin fails++; $display("FAIL sub_result: got %h, required fffffffe", result); end
    checks++; if (zero !== 1'b0) begin fails++; $display("FAIL sub_zero: got %b, required 0", zero); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int w;
    out_ready = 1'b0;
    send(3'b011, 32'h0000_00F0, 32'h0000_000F, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || result !== 32'h0000_00FF) begin
        fails++; $display("FAIL stall_hold: got valid=%b result=%h, required valid=1 result=ff", out_valid, result);
      end
      checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready: got %b, required 0", in_ready); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stall_single: got out_valid=%b, required 0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [2:0] codes [7];
    int w;
    codes = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(codes[$urandom_range(0, 6)], $urandom, $urandom, w);
      checks++; if (w !== 0) begin fails++; $display("FAIL b2b_stall: got %0d stall cycles, required 0", w); end
    end
    wait_drain();
  endtask

  task automatic test_shift;
    int w;
    out_ready = 1'b1;
    send(3'b100, 32'd1, 32'd4, w);
`ifdef ALU_SHIFT_EN
    begin
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < 6) begin
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL shift_in_ready: got %b, required 0", in_ready); end
        n++;
        @(negedge clk);
      end
      checks++; if (out_valid !== 1'b1 || result !== 32'h10) begin
        fails++; $display("FAIL shift_result: got valid=%b result=%h, required valid=1 result=10", out_valid, result);
      end
      @(posedge clk); #1;
    end
    send(3'b100, 32'h0000_00A5, 32'd0, w);
    send(3'b100, 32'd3, 32'd31, w);
    wait_drain();
`else
    @(negedge clk);
    checks++; if (illegal !== 1'b1 || result !== 32'd0 || out_valid !== 1'b1) begin
      fails++; $display("FAIL sll_illegal: got valid=%b illegal=%b result=%h, required 1 1 0", out_valid, illegal, result);
    end
    @(posedge clk); #1;
`endif
  endtask

  task automatic test_illegal;
    int w;
    out_ready = 1'b1;
    send(3'b111, 32'h1234_5678, 32'h9ABC_DEF0, w);
    @(negedge clk);
    checks++; if (illegal !== 1'b1 || zero !== 1'b1 || result !== 32'd0) begin
      fails++; $display("FAIL code111: got illegal=%b zero=%b result=%h, required 1 1 0", illegal, zero, result);
    end
    @(posedge clk); #1;
    send(3'b110, 32'd1, 32'd1, w);
    wait_drain();
  endtask

  task automatic test_reset_mid;
    int w;
    int bad = 0;
`ifdef ALU_SHIFT_EN
    out_ready = 1'b1;
    send(3'b100, 32'd1, 32'd20, w);
`else
    out_ready = 1'b0;
    send(3'b000, 32'd3, 32'd4, w);
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    checks++; if (out_valid !== 1'b0 || result !== 32'd0) begin
      fails++; $display("FAIL midrst_clear: got valid=%b result=%h, required 0 0", out_valid, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midrst_in_ready: got %b, required 1", in_ready); end
    for (int i = 0; i < 25; i++) begin
      if (out_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++; if (bad !== 0) begin fails++; $display("FAIL midrst_no_result: got %0d valid cycles, required 0", bad); end
    @(posedge clk); #1;
    send(3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, w);
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_wrap();
    test_slt_sub();
    test_backpressure();
    test_back_to_back();
    test_shift();
    test_illegal();
    test_reset_mid();
    wait_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
